// File: rtl/button_debounce_bank.sv
// button_debounce_bank: CHANNELS independent button debouncers with press/release,
// long-press (o_hold) and optional auto-repeat (o_repeat) pulses.
// Optional feature macro: BUTTON_DEBOUNCE_REPEAT_EN enables the o_repeat pulse train;
// without it o_repeat is tied to 0 and no repeat counter exists.

module button_debounce_lane #(
  parameter int CNT_W         = 10,
  parameter int HOLD_CYCLES   = 12000000,
  parameter int REPEAT_CYCLES = 2400000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_state,
  output logic o_ondn,
  output logic o_onup,
  output logic o_hold,
  output logic o_repeat
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {S_REL = 2'd0, S_PRS = 2'd1, S_HLD = 2'd2} fsm_t;

  // Zero-length hold/repeat periods make no sense; stop elaboration on them.
  if (HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_chk
    $error("button_debounce_lane: HOLD_CYCLES and REPEAT_CYCLES must be >= 1");
  end

  logic             r_sync0, r_sync1;
  logic [CNT_W-1:0] r_cnt;
  logic             r_state;
  logic [HW-1:0]    r_hcnt;
  fsm_t             r_fsm, w_fsm_nxt;
  logic             w_diff, w_done, w_tgl, w_rise, w_fall;
  logic             w_hold_hit, w_hold_fire;

  assign w_diff     = r_sync1 ^ r_state;
  assign w_done     = &r_cnt;
  assign w_tgl      = w_diff & w_done;
  assign w_rise     = w_tgl & ~r_state;
  assign w_fall     = w_tgl & r_state;
  assign w_hold_hit = (r_hcnt == HOLD_LAST);
  assign o_state    = r_state;

  // Two-flop synchroniser for the asynchronous button level.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
    end else begin
      r_sync0 <= i_btn;
      r_sync1 <= r_sync0;
    end
  end

  // Stability counter: a differing level must persist until the counter is all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_state <= 1'b0;
    end else if (!w_diff) begin
      r_cnt   <= '0;
    end else if (w_done) begin
      r_cnt   <= '0;
      r_state <= ~r_state;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  // Hold counter: restarts on each press, counts in PRESSED, parks at the last value.
  always_ff @(posedge clk) begin
    if (reset || w_rise)
      r_hcnt <= '0;
    else if (r_fsm == S_PRS && !w_hold_hit)
      r_hcnt <= r_hcnt + HW'(1);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_fsm <= S_REL;
    else       r_fsm <= w_fsm_nxt;
  end

  // FSM next state; a release always takes priority over a hold.
  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      S_REL:   if (w_rise) w_fsm_nxt = S_PRS;
      S_PRS:   if (w_fall) w_fsm_nxt = S_REL;
               else if (w_hold_hit) w_fsm_nxt = S_HLD;
      S_HLD:   if (w_fall) w_fsm_nxt = S_REL;
      default: w_fsm_nxt = S_REL;
    endcase
  end

  // FSM output strobe: hold fires once, on the PRESSED->HELD transition only.
  always_comb begin
    w_hold_fire = (r_fsm == S_PRS) && w_hold_hit && !w_fall;
  end

  // Registered edge/hold pulses, asserted on the edge the state changes.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_ondn <= 1'b0;
      o_onup <= 1'b0;
      o_hold <= 1'b0;
    end else begin
      o_ondn <= w_rise;
      o_onup <= w_fall;
      o_hold <= w_hold_fire;
    end
  end

`ifdef BUTTON_DEBOUNCE_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] r_rcnt;
  logic          w_rep_hit, w_rep_fire;

  assign w_rep_hit = (r_rcnt == REP_LAST);

  // Repeat strobe: periodic in HELD, suppressed on the release edge.
  always_comb begin
    w_rep_fire = (r_fsm == S_HLD) && w_rep_hit && !w_fall;
  end

  // Repeat counter: held at 0 outside HELD, so it starts fresh on the hold edge.
  always_ff @(posedge clk) begin
    if (reset || r_fsm != S_HLD || w_rep_hit)
      r_rcnt <= '0;
    else
      r_rcnt <= r_rcnt + RW'(1);
  end

  // Registered repeat pulse.
  always_ff @(posedge clk) begin
    if (reset) o_repeat <= 1'b0;
    else       o_repeat <= w_rep_fire;
  end
`else
  assign o_repeat = 1'b0;
`endif

endmodule

module button_debounce_bank #(
  parameter int CHANNELS      = 8,
  parameter int CNT_W         = 10,
  parameter int HOLD_CYCLES   = 12000000,
  parameter int REPEAT_CYCLES = 2400000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] i_btn,
  output logic [CHANNELS-1:0] o_state,
  output logic [CHANNELS-1:0] o_ondn,
  output logic [CHANNELS-1:0] o_onup,
  output logic [CHANNELS-1:0] o_hold,
  output logic [CHANNELS-1:0] o_repeat
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    button_debounce_lane #(
      .CNT_W        (CNT_W),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .i_btn   (i_btn[g]),
      .o_state (o_state[g]),
      .o_ondn  (o_ondn[g]),
      .o_onup  (o_onup[g]),
      .o_hold  (o_hold[g]),
      .o_repeat(o_repeat[g])
    );
  end

endmodule

// File: tb/tb_button_debounce_bank.sv
// Directed bench for button_debounce_bank (CHANNELS=4, CNT_W=4, HOLD=100, REPEAT=20).
// Expected repeat behaviour follows BUTTON_DEBOUNCE_REPEAT_EN when it is defined.

module tb_button_debounce_bank;
  localparam int CH = 4;
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] i_btn;
  logic [CH-1:0] o_state, o_ondn, o_onup, o_hold, o_repeat;

  int nvec = 0;
  int nerr = 0;

  // cumulative pulse counts (monitor) and snapshots (stimulus)
  int n_ondn[CH], n_onup[CH], n_hold[CH], n_rep[CH], n_hi[CH];
  int b_ondn[CH], b_onup[CH], b_hold[CH], b_rep[CH], b_hi[CH];

  button_debounce_bank #(
    .CHANNELS(CH), .CNT_W(4), .HOLD_CYCLES(100), .REPEAT_CYCLES(20)
  ) dut (
    .clk(clk), .reset(reset), .i_btn(i_btn),
    .o_state(o_state), .o_ondn(o_ondn), .o_onup(o_onup),
    .o_hold(o_hold), .o_repeat(o_repeat)
  );

  always #5 clk = ~clk;

  initial begin
    for (int c = 0; c < CH; c++) begin
      n_ondn[c] = 0; n_onup[c] = 0; n_hold[c] = 0; n_rep[c] = 0; n_hi[c] = 0;
    end
  end

  always @(negedge clk) begin
    for (int c = 0; c < CH; c++) begin
      if (o_ondn[c])   n_ondn[c] = n_ondn[c] + 1;
      if (o_onup[c])   n_onup[c] = n_onup[c] + 1;
      if (o_hold[c])   n_hold[c] = n_hold[c] + 1;
      if (o_repeat[c]) n_rep[c]  = n_rep[c] + 1;
      if (o_state[c])  n_hi[c]   = n_hi[c] + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snap();
    for (int c = 0; c < CH; c++) begin
      b_ondn[c] = n_ondn[c]; b_onup[c] = n_onup[c]; b_hold[c] = n_hold[c];
      b_rep[c]  = n_rep[c];  b_hi[c]   = n_hi[c];
    end
  endtask

  initial begin
    reset = 1'b1;
    i_btn = '0;
    ticks(3);
    chk("rst_state",  o_state,  0);
    chk("rst_ondn",   o_ondn,   0);
    chk("rst_onup",   o_onup,   0);
    chk("rst_hold",   o_hold,   0);
    chk("rst_repeat", o_repeat, 0);
    reset = 1'b0;
    ticks(2);

    // 1 + 4: press ch0, hold, repeat, release
    snap();
    i_btn = 4'b0001;
    ticks(17);
    chk("t1_pre_state", o_state, 4'b0000);
    ticks(1);
    chk("t1_state", o_state, 4'b0001);
    chk("t1_ondn",  o_ondn,  4'b0001);
    ticks(1);
    chk("t1_ondn_1cyc", o_ondn, 4'b0000);
    ticks(98);
    chk("t4_hold_early", o_hold, 4'b0000);
    ticks(1);
    chk("t4_hold", o_hold, 4'b0001);
    ticks(1);
    chk("t4_hold_1cyc", o_hold, 4'b0000);
    ticks(18);
    chk("t4_rep_early", o_repeat, 4'b0000);
    ticks(1);
    chk("t4_rep20", o_repeat, REP ? 4'b0001 : 4'b0000);
    ticks(20);
    chk("t4_rep40", o_repeat, REP ? 4'b0001 : 4'b0000);
    ticks(20);
    chk("t4_rep60", o_repeat, REP ? 4'b0001 : 4'b0000);
    i_btn = 4'b0000;
    ticks(17);
    chk("t4_rel_pre", o_state, 4'b0001);
    ticks(1);
    chk("t4_rel_state", o_state, 4'b0000);
    chk("t4_onup", o_onup, 4'b0001);
    ticks(40);
    chk("t4_n_hold0", n_hold[0] - b_hold[0], 1);
    chk("t4_n_rep0",  n_rep[0]  - b_rep[0],  REP ? 3 : 0);
    chk("t4_n_ondn0", n_ondn[0] - b_ondn[0], 1);
    chk("t4_n_onup0", n_onup[0] - b_onup[0], 1);
    chk("t1_n_ondn_other", n_ondn[1] - b_ondn[1] + n_ondn[2] - b_ondn[2] + n_ondn[3] - b_ondn[3], 0);

    // 2: short glitch on ch1 is rejected
    snap();
    i_btn = 4'b0010;
    ticks(10);
    i_btn = 4'b0000;
    ticks(30);
    chk("t2_state", o_state, 4'b0000);
    chk("t2_n_ondn1", n_ondn[1] - b_ondn[1], 0);
    chk("t2_n_onup1", n_onup[1] - b_onup[1], 0);
    chk("t2_n_hi1",   n_hi[1]   - b_hi[1],   0);

    // 3: bouncing ch2 settles high, then released
    snap();
    for (int k = 0; k < 8; k++) begin
      i_btn[2] = (k % 2 == 0);
      ticks(5);
    end
    i_btn[2] = 1'b1;
    ticks(17);
    chk("t3_pre_state", o_state, 4'b0000);
    chk("t3_n_ondn2_bounce", n_ondn[2] - b_ondn[2], 0);
    ticks(1);
    chk("t3_state", o_state, 4'b0100);
    chk("t3_ondn",  o_ondn,  4'b0100);
    ticks(2);
    i_btn[2] = 1'b0;
    ticks(17);
    chk("t3_rel_pre", o_state, 4'b0100);
    ticks(1);
    chk("t3_onup", o_onup, 4'b0100);
    ticks(5);
    chk("t3_n_ondn2", n_ondn[2] - b_ondn[2], 1);
    chk("t3_n_onup2", n_onup[2] - b_onup[2], 1);
    chk("t3_n_hold2", n_hold[2] - b_hold[2], 0);

    // 5: reset mid-debounce on ch3 (counter = 8), button still held
    snap();
    i_btn = 4'b1000;
    ticks(10);
    reset = 1'b1;
    ticks(1);
    reset = 1'b0;
    chk("t5_rst_state", o_state, 4'b0000);
    chk("t5_rst_ondn",  o_ondn,  4'b0000);
    ticks(17);
    chk("t5_pre_state", o_state, 4'b0000);
    ticks(1);
    chk("t5_state", o_state, 4'b1000);
    chk("t5_ondn",  o_ondn,  4'b1000);
    i_btn = 4'b0000;
    ticks(18);
    chk("t5_onup", o_onup, 4'b1000);
    ticks(5);
    chk("t5_n_ondn3", n_ondn[3] - b_ondn[3], 1);

    // 6: ch1 and ch3 together, ch1 released during ch3 hold count
    snap();
    i_btn = 4'b1010;
    ticks(17);
    chk("t6_pre_state", o_state, 4'b0000);
    ticks(1);
    chk("t6_ondn", o_ondn, 4'b1010);
    ticks(9);
    i_btn = 4'b1000;
    ticks(17);
    chk("t6_rel_pre", o_state, 4'b1010);
    ticks(1);
    chk("t6_state", o_state, 4'b1000);
    chk("t6_onup1", o_onup, 4'b0010);
    ticks(72);
    chk("t6_hold_early", o_hold, 4'b0000);
    ticks(1);
    chk("t6_hold3", o_hold, 4'b1000);
    i_btn = 4'b0000;
    ticks(18);
    chk("t6_onup3", o_onup, 4'b1000);
    ticks(5);
    chk("t6_n_hold1", n_hold[1] - b_hold[1], 0);
    chk("t6_n_hold3", n_hold[3] - b_hold[3], 1);
    chk("t6_n_onup1", n_onup[1] - b_onup[1], 1);
    chk("t6_n_rep3",  n_rep[3]  - b_rep[3],  0);

    // 7: release lands on the hold edge -> release wins
    snap();
    i_btn = 4'b0100;
    ticks(18);
    chk("t7_ondn", o_ondn, 4'b0100);
    ticks(82);
    i_btn = 4'b0000;
    ticks(17);
    chk("t7_pre_state", o_state, 4'b0100);
    ticks(1);
    chk("t7_state", o_state, 4'b0000);
    chk("t7_onup",  o_onup,  4'b0100);
    chk("t7_hold",  o_hold,  4'b0000);
    ticks(30);
    chk("t7_n_hold2", n_hold[2] - b_hold[2], 0);
    chk("t7_n_rep2",  n_rep[2]  - b_rep[2],  0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
